// File: rtl/pic_addr_pkg.sv
// Shared alias-mode encoding for the PIC16F file-register address generator.
package pic_addr_pkg;

    typedef logic [1:0] alias_mode_t;

    localparam alias_mode_t ALIAS_INDF    = 2'd0;
    localparam alias_mode_t ALIAS_POSTINC = 2'd1;
    localparam alias_mode_t ALIAS_POSTDEC = 2'd2;
    localparam alias_mode_t ALIAS_PREINC  = 2'd3;

    // Increment and decrement work modulo 2^FSR_W, so no carry is needed.
    function automatic logic is_inc_mode(input alias_mode_t mode);
        return (mode == ALIAS_POSTINC) || (mode == ALIAS_PREINC);
    endfunction

endpackage

// File: rtl/fsr_reg.sv
// One FSR pointer: an explicit write takes priority over increment/decrement.
module fsr_reg
    import pic_addr_pkg::*;
#(
    parameter int FSR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [FSR_W-1:0] wdata,
    input  logic             inc,
    input  logic             dec,
    output logic [FSR_W-1:0] q
);

    logic [FSR_W-1:0] fsr_reg_q;
    logic [FSR_W-1:0] fsr_next;

    always_comb begin
        fsr_next = fsr_reg_q;
        if (we) begin
            fsr_next = wdata;
        end else if (inc) begin
            fsr_next = fsr_reg_q + 1'b1;
        end else if (dec) begin
            fsr_next = fsr_reg_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsr_reg_q <= '0;
        end else begin
            fsr_reg_q <= fsr_next;
        end
    end

    assign q = fsr_reg_q;

endmodule

// File: rtl/ram_file_address_gen.sv
// RAM file address generator: direct {rp, opcode} or indirect {irp, FSRn} via alias window.
// Optional feature macro FSR_AUTOMOD_EN enables post-inc/post-dec/pre-inc alias modes.
module ram_file_address_gen
    import pic_addr_pkg::*;
#(
    parameter int               NUM_FSR    = 2,
    parameter int               FSR_W      = 8,
    parameter int               OPC_W      = 7,
    parameter logic [OPC_W-1:0] ALIAS_BASE = '0,
    localparam int              SEL_W      = (NUM_FSR > 1) ? $clog2(NUM_FSR) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               status_rp,
    input  logic                     status_irp,
    input  logic [OPC_W-1:0]         opcode_address,
    input  logic                     access_commit,
    input  logic                     fsr_we,
    input  logic [SEL_W-1:0]         fsr_wsel,
    input  logic [FSR_W-1:0]         fsr_wdata,
    output logic [FSR_W:0]           ram_file_address,
    output logic                     indirect,
    output logic                     null_access,
    output logic [NUM_FSR*FSR_W-1:0] fsr_q
);

    localparam int ADDR_W = FSR_W + 1;
    localparam int DIR_W  = OPC_W + 2;
    localparam logic [OPC_W:0] OPC_WIN = (OPC_W + 1)'(4 * NUM_FSR);
    localparam logic [FSR_W:0] PTR_WIN = (FSR_W + 1)'(4 * NUM_FSR);
    localparam logic [FSR_W:0] PTR_BASE = (FSR_W + 1)'(ALIAS_BASE);

    logic [FSR_W-1:0]  fsr_arr [NUM_FSR];
    logic [OPC_W:0]    opc_off;
    logic              alias_hit;
    logic [SEL_W-1:0]  alias_sel;
    alias_mode_t       alias_mode;
    logic [FSR_W-1:0]  ptr_base;
    logic [FSR_W-1:0]  ptr_eff;
    logic [FSR_W:0]    ptr_off;
    logic              ptr_in_window;
    logic [DIR_W-1:0]  direct_addr;
    logic [ADDR_W-1:0] direct_ext;
    logic              update_en;

    // Alias decode ignores rp: the window is mirrored in every bank.
    assign opc_off   = {1'b0, opcode_address} - {1'b0, ALIAS_BASE};
    assign alias_hit = !opc_off[OPC_W] && (opc_off < OPC_WIN);
    assign alias_sel = opc_off[2 +: SEL_W];

`ifdef FSR_AUTOMOD_EN
    assign alias_mode = alias_mode_t'(opc_off[1:0]);
`else
    assign alias_mode = ALIAS_INDF;
`endif

    always_comb begin
        ptr_base = '0;
        for (int i = 0; i < NUM_FSR; i++) begin
            if (alias_sel == SEL_W'(i)) begin
                ptr_base = fsr_arr[i];
            end
        end
    end

    assign ptr_eff = (alias_mode == ALIAS_PREINC) ? ptr_base + 1'b1 : ptr_base;

    // Full-width compare covers both "low bits in window" and "upper bits zero".
    assign ptr_off       = {1'b0, ptr_eff} - PTR_BASE;
    assign ptr_in_window = !ptr_off[FSR_W] && (ptr_off < PTR_WIN);

    assign direct_addr = {status_rp, opcode_address};

    generate
        if (DIR_W >= ADDR_W) begin : g_dir_trunc
            assign direct_ext = direct_addr[ADDR_W-1:0];
        end else begin : g_dir_ext
            assign direct_ext = {{(ADDR_W - DIR_W){1'b0}}, direct_addr};
        end
    endgenerate

    assign indirect         = alias_hit;
    assign null_access      = alias_hit && ptr_in_window;
    assign ram_file_address = alias_hit ? {status_irp, ptr_eff} : direct_ext;

    assign update_en = access_commit && alias_hit && !null_access;

    generate
        for (genvar gi = 0; gi < NUM_FSR; gi++) begin : g_fsr
            logic sel_hit;
            logic we_g;
            logic inc_g;
            logic dec_g;

            assign sel_hit = (alias_sel == SEL_W'(gi));
            assign we_g    = fsr_we && (fsr_wsel == SEL_W'(gi));
            assign inc_g   = update_en && sel_hit && is_inc_mode(alias_mode);
            assign dec_g   = update_en && sel_hit && (alias_mode == ALIAS_POSTDEC);

            fsr_reg #(
                .FSR_W (FSR_W)
            ) u_fsr (
                .clk   (clk),
                .rst   (rst),
                .we    (we_g),
                .wdata (fsr_wdata),
                .inc   (inc_g),
                .dec   (dec_g),
                .q     (fsr_arr[gi])
            );

            assign fsr_q[gi*FSR_W +: FSR_W] = fsr_arr[gi];
        end
    endgenerate

endmodule

// File: tb/tb_ram_file_address_gen.sv
// Randomised bench for ram_file_address_gen with an arithmetic reference model and literal pins.
module tb_ram_file_address_gen;

    localparam int NUM_FSR = 2;
    localparam int FSR_W   = 8;
    localparam int OPC_W   = 7;
    localparam logic [OPC_W-1:0] AB = 7'h08;
`ifdef FSR_AUTOMOD_EN
    localparam bit AUTOMOD = 1'b1;
`else
    localparam bit AUTOMOD = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic [1:0]               status_rp;
    logic                     status_irp;
    logic [OPC_W-1:0]         opcode_address;
    logic                     access_commit;
    logic                     fsr_we;
    logic [0:0]               fsr_wsel;
    logic [FSR_W-1:0]         fsr_wdata;
    logic [FSR_W:0]           ram_file_address;
    logic                     indirect;
    logic                     null_access;
    logic [NUM_FSR*FSR_W-1:0] fsr_q;

    int vectors = 0;
    int miscompares = 0;
    int mf [NUM_FSR];

    always #5 clk = ~clk;

    ram_file_address_gen #(
        .NUM_FSR    (NUM_FSR),
        .FSR_W      (FSR_W),
        .OPC_W      (OPC_W),
        .ALIAS_BASE (AB)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .status_rp        (status_rp),
        .status_irp       (status_irp),
        .opcode_address   (opcode_address),
        .access_commit    (access_commit),
        .fsr_we           (fsr_we),
        .fsr_wsel         (fsr_wsel),
        .fsr_wdata        (fsr_wdata),
        .ram_file_address (ram_file_address),
        .indirect         (indirect),
        .null_access      (null_access),
        .fsr_q            (fsr_q)
    );

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int model_fsrq();
        int v = 0;
        for (int i = 0; i < NUM_FSR; i++) v += mf[i] << (i * FSR_W);
        return v;
    endfunction

    // Reference: plain arithmetic on the current inputs and modelled FSRs.
    task automatic model_out(output int a, output int ind, output int nul,
                             output int n, output int m);
        int opc = int'(opcode_address);
        int base = int'(AB);
        int p;
        a = 0; ind = 0; nul = 0; n = 0; m = 0;
        if (opc >= base && opc < base + 4 * NUM_FSR) begin
            ind = 1;
            n   = (opc - base) / 4;
            m   = AUTOMOD ? (opc - base) % 4 : 0;
            p   = (mf[n] + (m == 3 ? 1 : 0)) % 256;
            a   = int'(status_irp) * 256 + p;
            nul = (p >= base && p < base + 4 * NUM_FSR) ? 1 : 0;
        end else begin
            a = int'(status_rp) * 128 + opc;
        end
    endtask

    task automatic cycle(input int rp, input int irp, input int opc, input int commit,
                         input int we, input int wsel, input int wdata,
                         output int got_addr, output int got_null);
        int a, ind, nul, n, m;
        int nxt [NUM_FSR];
        @(negedge clk);
        status_rp      = 2'(rp);
        status_irp     = 1'(irp);
        opcode_address = 7'(opc);
        access_commit  = 1'(commit);
        fsr_we         = 1'(we);
        fsr_wsel       = 1'(wsel);
        fsr_wdata      = 8'(wdata);
        #1;
        model_out(a, ind, nul, n, m);
        check("addr", int'(ram_file_address), a);
        check("indirect", int'(indirect), ind);
        check("null_access", int'(null_access), nul);
        check("fsr_q_pre", int'(fsr_q), model_fsrq());
        got_addr = int'(ram_file_address);
        got_null = int'(null_access);
        nxt = mf;
        if (commit != 0 && ind != 0 && nul == 0) begin
            if (m == 1 || m == 3) nxt[n] = (mf[n] + 1) % 256;
            if (m == 2) nxt[n] = (mf[n] + 255) % 256;
        end
        if (we != 0) nxt[wsel] = wdata;
        @(posedge clk);
        mf = nxt;
        #1;
        check("fsr_q_post", int'(fsr_q), model_fsrq());
        $display("vec rp=%0d irp=%0d opc=%02h commit=%0d we=%0d/%0d/%02h -> addr=%03h ind=%0d null=%0d fsr_q=%04h",
                 rp, irp, opc, commit, we, wsel, wdata, got_addr, ind, got_null, fsr_q);
    endtask

    int ga, gn;
    int b = int'(AB);

    initial begin
        rst = 1'b1;
        status_rp = '0; status_irp = 1'b0; opcode_address = '0;
        access_commit = 1'b0; fsr_we = 1'b0; fsr_wsel = '0; fsr_wdata = '0;
        for (int i = 0; i < NUM_FSR; i++) mf[i] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: direct access after reset
        cycle(1, 0, 'h25, 0, 0, 0, 0, ga, gn);
        check("t1_addr", ga, 'h0A5);
        check("t1_fsrs", int'(fsr_q), 0);

        // 2: FSR1=0x30, POSTINC alias of FSR1
        cycle(0, 1, 'h00, 0, 1, 1, 'h30, ga, gn);
        cycle(0, 1, b + 5, 1, 0, 0, 0, ga, gn);
        check("t2_addr", ga, 'h130);
        check("t2_fsr1", int'(fsr_q[15:8]), AUTOMOD ? 'h31 : 'h30);

        // 3: POSTDEC wrap 0x00 -> 0xFF, PREINC wrap 0xFF -> 0x00
        cycle(0, 1, 'h00, 0, 1, 0, 'h00, ga, gn);
        cycle(0, 1, b + 2, 1, 0, 0, 0, ga, gn);
        check("t3_dec_addr", ga, 'h100);
        check("t3_dec_fsr0", int'(fsr_q[7:0]), AUTOMOD ? 'hFF : 'h00);
        cycle(0, 1, 'h00, 0, 1, 0, 'hFF, ga, gn);
        cycle(0, 1, b + 3, 1, 0, 0, 0, ga, gn);
        check("t3_inc_addr", ga, AUTOMOD ? 'h100 : 'h1FF);
        check("t3_inc_fsr0", int'(fsr_q[7:0]), AUTOMOD ? 'h00 : 'hFF);

        // 4: explicit write beats auto-modify on same FSR; different FSRs both act
        cycle(0, 0, b + 1, 1, 1, 0, 'h50, ga, gn);
        check("t4_same", int'(fsr_q[7:0]), 'h50);
        cycle(0, 0, b + 5, 1, 1, 0, 'h60, ga, gn);
        check("t4_diff_fsr0", int'(fsr_q[7:0]), 'h60);
        check("t4_diff_fsr1", int'(fsr_q[15:8]), AUTOMOD ? 'h32 : 'h30);

        // 5: pointer into alias window -> null access, no modify
        cycle(0, 0, 'h00, 0, 1, 0, b + 2, ga, gn);
        cycle(0, 0, b + 1, 1, 0, 0, 0, ga, gn);
        check("t5_null", gn, 1);
        check("t5_fsr0", int'(fsr_q[7:0]), b + 2);

        // 6: PREINC alias with FSR0=0x10
        cycle(0, 0, 'h00, 0, 1, 0, 'h10, ga, gn);
        cycle(0, 1, b + 3, 1, 0, 0, 0, ga, gn);
        check("t6_addr", ga, AUTOMOD ? 'h111 : 'h110);
        check("t6_fsr0", int'(fsr_q[7:0]), AUTOMOD ? 'h11 : 'h10);

        // Direct commit must not touch FSRs
        cycle(3, 1, 'h7F, 1, 0, 0, 0, ga, gn);
        check("direct_commit", int'(fsr_q[7:0]), AUTOMOD ? 'h11 : 'h10);

        for (int k = 0; k < 400; k++) begin
            int opc, wd, r;
            r   = int'($urandom_range(0, 9));
            opc = (r < 7) ? b + int'($urandom_range(0, 4 * NUM_FSR - 1))
                          : int'($urandom_range(0, 127));
            r   = int'($urandom_range(0, 3));
            wd  = (r == 0) ? b + int'($urandom_range(0, 7))
                : (r == 1) ? ((($urandom_range(0, 1)) != 0) ? 'hFF : 'h00)
                : int'($urandom_range(0, 255));
            if (k == 200) begin
                // Asynchronous reset mid-run with a commit pending
                @(negedge clk);
                opcode_address = 7'(b + 1);
                access_commit  = 1'b1;
                rst            = 1'b1;
                #1;
                for (int i = 0; i < NUM_FSR; i++) mf[i] = 0;
                check("midrun_rst", int'(fsr_q), 0);
                @(posedge clk);
                #1;
                check("midrun_rst_edge", int'(fsr_q), 0);
                @(negedge clk);
                rst = 1'b0;
            end
            cycle(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), opc,
                  int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 1 : 0,
                  int'($urandom_range(0, 1)), wd, ga, gn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
